// File: rtl/montgomery_exp_ctrl_if.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : montgomery_exp_ctrl_if
// Purpose  : Bus between the exponentiation controller and an external
//            Montgomery multiplier.
// Signals  : mul_start  - one-cycle operation request (controller -> mult)
//            mul_a/b/m  - operands and modulus       (controller -> mult)
//            mul_result - product                    (mult -> controller)
//            mul_done   - product-valid strobe       (mult -> controller)
// Modports : master (controller side), slave (multiplier side)
// Revision : 1.0 - initial release
// ============================================================================
interface montgomery_exp_ctrl_if;
  logic         mul_start;
  logic [511:0] mul_a;
  logic [511:0] mul_b;
  logic [511:0] mul_m;
  logic [511:0] mul_result;
  logic         mul_done;

  modport master (
    output mul_start, mul_a, mul_b, mul_m,
    input  mul_result, mul_done
  );

  modport slave (
    input  mul_start, mul_a, mul_b, mul_m,
    output mul_result, mul_done
  );
endinterface
`default_nettype wire

// File: rtl/montgomery_exp_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : montgomery_exp_ctrl
// Purpose  : Left-to-right square-and-multiply controller. Computes
//            x^e in Montgomery form by sequencing an external multiplier
//            over exponent bits [e_len-1:0], MSB first.
// Ports    : clk, resetn (async, active low)
//            start            - one-cycle request, sampled only in IDLE
//            in_x/in_r/in_e/in_m - base, Montgomery one, exponent, modulus
//            e_len            - exponent bits to process (0..512)
//            mul              - multiplier bus (master modport)
//            result           - final accumulator, held until next start
//            done             - one-cycle completion pulse
//            busy             - high in every state except IDLE
// Config   : EXP_CONST_TIME_EN - when defined, every bit performs a square
//            and a multiply; the multiply product is kept only for 1 bits.
// Revision : 1.0 - initial release
// ============================================================================
module montgomery_exp_ctrl (
  input  wire logic              clk,
  input  wire logic              resetn,
  input  wire logic              start,
  input  wire logic [511:0]      in_x,
  input  wire logic [511:0]      in_r,
  input  wire logic [511:0]      in_e,
  input  wire logic [511:0]      in_m,
  input  wire logic [9:0]        e_len,
  montgomery_exp_ctrl_if.master  mul,
  output logic      [511:0]      result,
  output logic                   done,
  output logic                   busy
);

  typedef enum logic [3:0] {
    IDLE      = 4'd0,
    LOAD      = 4'd1,
    SQR_ISSUE = 4'd2,
    SQR_WAIT  = 4'd3,
    MUL_ISSUE = 4'd4,
    MUL_WAIT  = 4'd5,
    NEXT      = 4'd6,
    FINISH    = 4'd7
  } state_t;

  state_t       r_state;
  state_t       w_stateNext;
  logic [511:0] r_acc;
  logic [511:0] r_x;
  logic [511:0] r_e;
  logic [511:0] r_m;
  logic [9:0]   r_len;
  logic [9:0]   r_idx;
  logic [511:0] r_result;
  logic         r_done;
  logic         w_bit;

  // idx never exceeds 511 while a bit is being consumed, so the low 9 bits
  // address the exponent; bit 9 only matters for the idx==0 test.
  assign w_bit = r_e[r_idx[8:0]];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_state <= IDLE;
    else         r_state <= w_stateNext;
  end

  always_comb begin
    w_stateNext   = r_state;
    mul.mul_start = 1'b0;
    mul.mul_b     = r_x;
    case (r_state)
      IDLE:      if (start) w_stateNext = LOAD;
      LOAD:      w_stateNext = (r_len == 10'd0) ? FINISH : SQR_ISSUE;
      SQR_ISSUE: begin
        mul.mul_start = 1'b1;
        mul.mul_b     = r_acc;
        w_stateNext   = SQR_WAIT;
      end
      SQR_WAIT: begin
        // Keep the squaring operand on mul_b for the whole wait.
        mul.mul_b = r_acc;
        if (mul.mul_done) begin
`ifdef EXP_CONST_TIME_EN
          w_stateNext = MUL_ISSUE;
`else
          w_stateNext = w_bit ? MUL_ISSUE : NEXT;
`endif
        end
      end
      MUL_ISSUE: begin
        mul.mul_start = 1'b1;
        w_stateNext   = MUL_WAIT;
      end
      MUL_WAIT:  if (mul.mul_done) w_stateNext = NEXT;
      NEXT:      w_stateNext = (r_idx == 10'd0) ? FINISH : SQR_ISSUE;
      FINISH:    w_stateNext = IDLE;
      default:   w_stateNext = IDLE;
    endcase
  end

  // acc only changes on mul_done in a WAIT state and stays put otherwise,
  // so mul_a is stable for the full duration of each multiplication.
  assign mul.mul_a = r_acc;
  assign mul.mul_m = r_m;
  assign busy      = (r_state != IDLE);
  assign result    = r_result;
  assign done      = r_done;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_acc    <= '0;
      r_x      <= '0;
      r_e      <= '0;
      r_m      <= '0;
      r_len    <= '0;
      r_idx    <= '0;
      r_result <= '0;
      r_done   <= 1'b0;
    end else begin
      r_done <= (r_state == FINISH);
      case (r_state)
        IDLE: begin
          if (start) begin
            r_x   <= in_x;
            r_e   <= in_e;
            r_m   <= in_m;
            r_len <= e_len;
            r_acc <= in_r;
            // Wraps to 1023 for e_len==0; LOAD exits before idx is used.
            r_idx <= e_len - 10'd1;
          end
        end
        SQR_WAIT: begin
          if (mul.mul_done) r_acc <= mul.mul_result;
        end
        MUL_WAIT: begin
`ifdef EXP_CONST_TIME_EN
          // Dummy multiply for zero bits: product is dropped.
          if (mul.mul_done && w_bit) r_acc <= mul.mul_result;
`else
          if (mul.mul_done) r_acc <= mul.mul_result;
`endif
        end
        NEXT: begin
          if (r_idx != 10'd0) r_idx <= r_idx - 10'd1;
        end
        FINISH: r_result <= r_acc;
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire
